// File: rtl/pipe_pkg.sv
// Shared pipeline types and sizing used by the writeback stage and its scoreboard.
package pipe_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module wb_scoreboard #(
    parameter  int NREG = pipe_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREG-1:0] busy;

    // NOTE: sequential state uses non-blocking assignments so every bit samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                // Set wins on a same-index collision: the newer instruction is still outstanding.
                if (set_en && set_idx == AW'(i))
                    busy[i] <= 1'b1;
                else if (clr_en && clr_idx == AW'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

    // A register committing this cycle is served by the bypass, so it no longer stalls.
    assign rs1_busy = busy[rs1_addr] & ~(clr_en && clr_idx == rs1_addr);
    assign rs2_busy = busy[rs2_addr] & ~(clr_en && clr_idx == rs2_addr);

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Writeback stage: result select, register file with write-through read ports, and scoreboard.
module wb_regfile_scoreboard #(
    parameter  int XLEN = pipe_pkg::XLEN,
    parameter  int NREG = pipe_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic            wb_mem2reg,
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] wb_alu_res,
    output logic [XLEN-1:0] wb_result,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [XLEN-1:0] regs [NREG];
    logic            commit;
    logic            issue_set;

    assign wb_result = wb_mem2reg ? wb_data : wb_alu_res;
    assign commit    = wb_valid & wb_reg_write & (wb_rd != '0);
    assign issue_set = issue_valid & issue_we & (issue_rd != '0);

    // NOTE: the array is cleared by reset because reset must make every register read back zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[wb_rd] <= wb_result;
        end
    end

    // NOTE: each output gets a default first so no path through the block can infer a latch.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0)
            rs1_data = '0;
        else if (commit && wb_rd == rs1_addr)
            rs1_data = wb_result;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0)
            rs2_data = '0;
        else if (commit && wb_rd == rs2_addr)
            rs2_data = wb_result;
    end

    wb_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_set),
        .set_idx  (issue_rd),
        .clr_en   (commit),
        .clr_idx  (wb_rd),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: writeback select, bypass, x0, scoreboard and reset.
module tb_wb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid, wb_mem2reg, wb_reg_write;
    logic [AW-1:0]   wb_rd, rs1_addr, rs2_addr, issue_rd;
    logic [XLEN-1:0] wb_data, wb_alu_res;
    logic [XLEN-1:0] wb_result, rs1_data, rs2_data;
    logic            issue_valid, issue_we;
    logic            rs1_busy, rs2_busy;

    int n_assert = 0;
    int n_fail   = 0;

    wb_regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_mem2reg   (wb_mem2reg),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_alu_res   (wb_alu_res),
        .wb_result    (wb_result),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] observed,
                         input logic [XLEN-1:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_idle();
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem2reg = 1'b0;
        wb_rd = '0; wb_data = '0; wb_alu_res = '0;
    endtask

    task automatic wb_commit(input logic [AW-1:0] rd, input logic m2r,
                             input logic [XLEN-1:0] data, input logic [XLEN-1:0] alu);
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem2reg = m2r;
        wb_rd = rd; wb_data = data; wb_alu_res = alu;
    endtask

    task automatic issue(input logic en, input logic [AW-1:0] rd);
        issue_valid = en; issue_we = en; issue_rd = rd;
    endtask

    initial begin
        wb_idle();
        issue(1'b0, '0);
        rs1_addr = '0; rs2_addr = '0;
        rst = 1'b1;

        // 1: reset state; wb_result follows inputs even in reset
        rs1_addr = 4'd5; rs2_addr = 4'd0; wb_alu_res = 32'h0000_0011;
        #1;
        check("rst_rs1_data", rs1_data, 32'h0);
        check("rst_rs2_data", rs2_data, 32'h0);
        check("rst_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        check("rst_rs2_busy", {31'b0, rs2_busy}, 32'h0);
        check("rst_wb_result", wb_result, 32'h0000_0011);
        step();
        rst = 1'b0;
        step();

        // 2: ALU commit to x3, bypass before edge, stored after
        wb_commit(4'd3, 1'b0, 32'h0BAD_0BAD, 32'hDEAD_BEEF);
        rs1_addr = 4'd3;
        #1;
        check("alu_wb_result", wb_result, 32'hDEAD_BEEF);
        check("bypass_rs1_x3", rs1_data, 32'hDEAD_BEEF);
        step();
        wb_idle();
        #1;
        check("stored_rs1_x3", rs1_data, 32'hDEAD_BEEF);

        // 3: load commit to x7; a bubble with a new value must not write
        wb_commit(4'd7, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        #1;
        check("load_wb_result", wb_result, 32'h1234_5678);
        step();
        wb_idle();
        rs2_addr = 4'd7;
        #1;
        check("stored_rs2_x7", rs2_data, 32'h1234_5678);
        wb_commit(4'd7, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        wb_valid = 1'b0;
        #1;
        check("bubble_wb_result", wb_result, 32'hCAFE_F00D);
        check("bubble_no_bypass", rs2_data, 32'h1234_5678);
        step();
        wb_idle();
        #1;
        check("bubble_no_write_x7", rs2_data, 32'h1234_5678);

        // 4: x0 write ignored
        wb_commit(4'd0, 1'b0, 32'h0, 32'hAAAA_5555);
        rs1_addr = 4'd0;
        #1;
        check("x0_bypass_blocked", rs1_data, 32'h0);
        step();
        wb_idle();
        #1;
        check("x0_read_zero", rs1_data, 32'h0);
        check("x0_busy", {31'b0, rs1_busy}, 32'h0);

        // 5: scoreboard set, set-wins collision, clear; different-index set+clear
        rs2_addr = 4'd4;
        issue(1'b1, 4'd4);
        #1;
        check("busy4_before_edge", {31'b0, rs2_busy}, 32'h0);
        step();
        issue(1'b0, '0);
        #1;
        check("busy4_set", {31'b0, rs2_busy}, 32'h1);
        wb_commit(4'd4, 1'b0, 32'h0, 32'h0000_0444);
        issue(1'b1, 4'd4);
        #1;
        check("busy4_masked_by_commit", {31'b0, rs2_busy}, 32'h0);
        check("bypass_rs2_x4", rs2_data, 32'h0000_0444);
        step();
        wb_idle();
        issue(1'b0, '0);
        #1;
        check("busy4_set_wins", {31'b0, rs2_busy}, 32'h1);
        wb_commit(4'd4, 1'b0, 32'h0, 32'h0000_0555);
        issue(1'b1, 4'd6);
        step();
        wb_idle();
        issue(1'b0, '0);
        rs1_addr = 4'd6;
        #1;
        check("busy4_cleared", {31'b0, rs2_busy}, 32'h0);
        check("busy6_set_diff_idx", {31'b0, rs1_busy}, 32'h1);
        check("stored_rs2_x4", rs2_data, 32'h0000_0555);

        // 6: async reset mid-cycle clears regs and busy; commit during reset dropped
        wb_commit(4'd9, 1'b0, 32'h0, 32'h0000_0055);
        issue(1'b1, 4'd9);
        step();
        wb_idle();
        issue(1'b0, '0);
        rs1_addr = 4'd9; rs2_addr = 4'd6;
        #1;
        check("pre_rst_x9", rs1_data, 32'h0000_0055);
        check("pre_rst_busy9", {31'b0, rs1_busy}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_x9", rs1_data, 32'h0);
        check("async_rst_busy9", {31'b0, rs1_busy}, 32'h0);
        check("async_rst_busy6", {31'b0, rs2_busy}, 32'h0);
        wb_commit(4'd9, 1'b0, 32'h0, 32'h0000_0077);
        issue(1'b1, 4'd9);
        step();
        wb_idle();
        issue(1'b0, '0);
        #1;
        check("rst_commit_dropped", rs1_data, 32'h0);
        rst = 1'b0;
        rs2_addr = 4'd3;
        #1;
        check("post_rst_x9", rs1_data, 32'h0);
        check("post_rst_busy9", {31'b0, rs1_busy}, 32'h0);
        check("post_rst_x3", rs2_data, 32'h0);
        step();
        check("post_rst_x9_after_edge", rs1_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
